alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
- Round-robin controller that shares one combinational 32-bit ALU between N_REQ requesters.
- Accepts one operation per grant using a valid/ready handshake and latches its operands.
- Drives the ALU for one cycle, then returns the registered result tagged with the requester ID on a single response channel.
- Sits between the execution clients (sequencers, DMA address math) and the shared ALU instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 32, operand/result width; must match the ALU.
- SEL_W, 4, ALU opcode width.
- ID_W, clog2(N_REQ), derived localparam, response ID width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operation valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit set (one-hot or zero).
- req_a  in  N_REQ*DATA_W  packed operand A; slice i belongs to requester i.
- req_b  in  N_REQ*DATA_W  packed operand B.
- req_sel  in  N_REQ*SEL_W  packed ALU opcode.
- alu_a  out  DATA_W  to ALU operand A.
- alu_b  out  DATA_W  to ALU operand B.
- alu_sel  out  SEL_W  to ALU opcode.
- alu_out  in  DATA_W  ALU result.
- alu_carry  in  1  ALU carry-out.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester served.
- rsp_data  out  DATA_W  result.
- rsp_carry  out  1  carry-out.
- rsp_dz  out  1  divide-by-zero flag.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst high at a clock edge): state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id/rsp_data/rsp_carry/rsp_dz=0, operand registers=0, busy=0.
- Reset mid-operation: the in-flight operation is dropped with no response, and the controller returns to IDLE on the next edge.
- FSM states:
  - IDLE: grant g = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, … mod N_REQ. req_ready[g]=1 combinationally, other bits 0. If no valid, all ready bits are 0 and the FSM stays in IDLE. On the handshake edge, latch req_a/b/sel slice g and g into op regs, then go to EXEC.
  - EXEC (exactly 1 cycle): alu_a/alu_b/alu_sel = op regs. On the edge, capture alu_out/alu_carry into rsp regs, set rsp_id=g, set rsp_dz, go to RESP.
  - RESP: rsp_valid=1, all rsp_* outputs stable. When rsp_valid&rsp_ready: rr_ptr=(g+1) mod N_REQ, go to IDLE.
- No new grant is issued while in EXEC or RESP; req_ready is all-zero in those states.
- Latency: handshake at edge t, rsp_valid high from cycle t+2. Minimum issue interval is 3 cycles.
- Divide (sel=4'b0011) with B==0: rsp_data=0, rsp_carry=0, rsp_dz=1; alu_out is ignored. For all other cases rsp_dz=0.
- alu_a/b/sel hold the last op regs in IDLE and RESP; values are don't-care but stable (no X).
- req_ready depends only on state, rr_ptr and req_valid; it must not depend on rsp_ready.
- Requester contract: once req_valid is high, it stays high with stable operands until accepted. This is covered by a bench assertion, not RTL.
- Fairness: a continuously valid requester is granted within N_REQ grants.
- rr_ptr wraps from N_REQ-1 to 0.
- Back-pressure: rsp_ready low holds RESP indefinitely with outputs stable.

Decomposition:
- Shared package alu_share_pkg:
  - state enum {IDLE, EXEC, RESP};
  - opcode constant OP_DIV=4'b0011;
  - ID_W helper function.
- One natural sub-module: rr_arbiter (N_REQ request vector + pointer in, one-hot grant + encoded index out, purely combinational), reusable elsewhere.

Test Plan:
- Single request: req0 valid, A=5, B=7, sel=0000, rsp_ready=1; bench ALU model returns 12 → req_ready[0] high in the same cycle, rsp_valid 2 cycles later, rsp_id=0, rsp_data=12, rsp_carry=0, rsp_dz=0.
- All four valid continuously, rsp_ready=1 → grant order 0,1,2,3,0 with one grant every 3 cycles; no requester is skipped.
- Back-pressure: rsp_ready=0 for 10 cycles after a response appears → rsp_* stable, busy=1, req_ready all 0; once rsp_ready=1, the next grant occurs in the following IDLE cycle.
- Divide by zero: req2 sel=0011, A=100, B=0 → rsp_id=2, rsp_data=0, rsp_carry=0, rsp_dz=1. Then A=100, B=7 → rsp_data=14, rsp_dz=0.
- Carry path: req1 sel=0000, A=FFFFFFFF, B=1 → rsp_data=0, rsp_carry=1.
- Reset mid-operation: assert rst during EXEC → no rsp_valid, state IDLE, rr_ptr=0; with req3 and req0 both valid afterwards, req0 is granted first.

Source files
------------

// File: rtl/alu_share_pkg.sv
// Shared definitions for the shared-ALU controller.
//   state_t : controller FSM states
//   OP_DIV  : ALU opcode for divide (needs divide-by-zero handling)
//   id_w()  : width of a requester index for a given requester count
package alu_share_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] OP_DIV = 4'b0011;

   // A single requester index still needs one bit so ports never collapse.
   function automatic int id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector, bit i belongs to requester i
//   ptr       : highest-priority requester for this arbitration
//   grant     : one-hot grant (all zero when nothing requests)
//   grant_idx : encoded index of the granted requester
//   any_req   : at least one request present
module rr_arbiter
   import alu_share_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int ID_W  = id_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_idx,
   output logic             any_req
);

   localparam int unsigned NR = N_REQ;

   int unsigned idx;
   logic        found;

   // Scan ptr, ptr+1, ... modulo N_REQ; the first hit wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int unsigned k = 0; k < NR; k++) begin
         idx = (32'(ptr) + k) % NR;
         if (!found && req[ID_W'(idx)]) begin
            found                = 1'b1;
            grant[ID_W'(idx)]    = 1'b1;
            grant_idx            = ID_W'(idx);
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one combinational ALU between N_REQ
// requesters. One operation is accepted per grant, executed for one cycle
// on the ALU, and returned registered on a single response channel.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a/req_b/req_sel : packed per-requester operands and opcode
//   alu_a/alu_b/alu_sel : drive the shared ALU
//   alu_out/alu_carry   : ALU result
//   rsp_*               : response channel (valid/ready, id, data, carry, dz)
//   busy                : controller not idle
module alu_share_ctrl
   import alu_share_pkg::*;
#(
   parameter  int N_REQ  = 4,
   parameter  int DATA_W = 32,
   parameter  int SEL_W  = 4,
   localparam int ID_W   = id_w(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ*DATA_W-1:0] req_a,
   input  logic [N_REQ*DATA_W-1:0] req_b,
   input  logic [N_REQ*SEL_W-1:0]  req_sel,
   output logic [DATA_W-1:0]       alu_a,
   output logic [DATA_W-1:0]       alu_b,
   output logic [SEL_W-1:0]        alu_sel,
   input  logic [DATA_W-1:0]       alu_out,
   input  logic                    alu_carry,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [DATA_W-1:0]       rsp_data,
   output logic                    rsp_carry,
   output logic                    rsp_dz,
   output logic                    busy
);

   localparam int unsigned NR = N_REQ;

   state_t              state, state_nxt;
   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     op_id;
   logic [DATA_W-1:0]   op_a, op_b;
   logic [SEL_W-1:0]    op_sel;

   logic [N_REQ-1:0]    grant;
   logic [ID_W-1:0]     grant_idx;
   logic                any_req;

   logic [DATA_W-1:0]   sel_a, sel_b;
   logic [SEL_W-1:0]    sel_op;
   logic                div_zero;
   logic [ID_W-1:0]     ptr_after;

   rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_req   (any_req)
   );

   // One-hot grant lets the operand mux be a plain OR of masked slices.
   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_op = '0;
      for (int unsigned i = 0; i < NR; i++) begin
         if (grant[i]) begin
            sel_a  = sel_a  | req_a[i*DATA_W +: DATA_W];
            sel_b  = sel_b  | req_b[i*DATA_W +: DATA_W];
            sel_op = sel_op | req_sel[i*SEL_W +: SEL_W];
         end
      end
   end

   assign div_zero  = (op_sel == SEL_W'(OP_DIV)) && (op_b == '0);
   assign ptr_after = (op_id == ID_W'(N_REQ - 1)) ? '0 : op_id + ID_W'(1);

   // Operand registers feed the ALU in every state so its inputs never float.
   assign alu_a   = op_a;
   assign alu_b   = op_b;
   assign alu_sel = op_sel;

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      rsp_valid = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            req_ready = grant;
            if (any_req) state_nxt = EXEC;
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         op_id     <= '0;
         op_a      <= '0;
         op_b      <= '0;
         op_sel    <= '0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         rsp_carry <= 1'b0;
         rsp_dz    <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (any_req) begin
                  op_a   <= sel_a;
                  op_b   <= sel_b;
                  op_sel <= sel_op;
                  op_id  <= grant_idx;
               end
            end
            EXEC: begin
               rsp_id <= op_id;
               if (div_zero) begin
                  rsp_data  <= '0;
                  rsp_carry <= 1'b0;
                  rsp_dz    <= 1'b1;
               end else begin
                  rsp_data  <= alu_out;
                  rsp_carry <= alu_carry;
                  rsp_dz    <= 1'b0;
               end
            end
            RESP: begin
               // Pointer moves past the served requester only once delivered.
               if (rsp_ready) rr_ptr <= ptr_after;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: directed scenarios followed by
// randomized traffic, checked by a scoreboard against a reference model.
module tb_alu_share_ctrl;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int IW = 2;

   typedef struct {
      int          id;
      logic [31:0] data;
      logic        carry;
      logic        dz;
      int          cyc;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*DW-1:0]   req_a, req_b;
   logic [N*SW-1:0]   req_sel;
   logic [DW-1:0]     alu_a, alu_b, alu_out;
   logic [SW-1:0]     alu_sel;
   logic              alu_carry;
   logic              rsp_valid, rsp_ready;
   logic [IW-1:0]     rsp_id;
   logic [DW-1:0]     rsp_data;
   logic              rsp_carry, rsp_dz, busy;

   int                checks   = 0;
   int                failures = 0;
   int                cyc      = 0;
   int                mptr     = 0;
   exp_t              exp_q[$];
   int                grant_log[$];
   int                grant_cyc[$];
   logic [N-1:0]      auto_en;
   int unsigned       prob_pct;
   logic              rand_rsp;
   int                last_id;
   logic [31:0]       last_data;
   logic              last_carry, last_dz;

   always #5 clk = ~clk;

   alu_share_ctrl #(
      .N_REQ  (N),
      .DATA_W (DW),
      .SEL_W  (SW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sel   (req_sel),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_sel   (alu_sel),
      .alu_out   (alu_out),
      .alu_carry (alu_carry),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_carry (rsp_carry),
      .rsp_dz    (rsp_dz),
      .busy      (busy)
   );

   // Shared ALU stand-in; divide by zero yields garbage the DUT must mask.
   always_comb begin
      alu_out   = '0;
      alu_carry = 1'b0;
      case (alu_sel)
         4'd0: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
         4'd1: {alu_carry, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
         4'd2: alu_out = alu_a & alu_b;
         4'd3: begin
            if (alu_b == '0) begin
               alu_out   = 32'hFFFF_FFFF;
               alu_carry = 1'b1;
            end else begin
               alu_out = alu_a / alu_b;
            end
         end
         4'd4: alu_out = alu_a | alu_b;
         4'd5: alu_out = alu_a ^ alu_b;
         default: alu_out = alu_a;
      endcase
   end

   // Expected response for one operation, straight from the operation rules.
   function automatic exp_t ref_op(int id, logic [31:0] a, logic [31:0] b,
                                   logic [3:0] sel, int c);
      exp_t e;
      longint unsigned ua = a, ub = b;
      e.id = id; e.cyc = c; e.carry = 1'b0; e.dz = 1'b0; e.data = '0;
      case (sel)
         4'd0: begin e.data = 32'(ua + ub); e.carry = (ua + ub) > 64'hFFFF_FFFF; end
         4'd1: begin e.data = 32'(ua - ub); e.carry = (ua < ub); end
         4'd2: e.data = a & b;
         4'd3: begin
            if (b == 0) e.dz = 1'b1;
            else e.data = 32'(ua / ub);
         end
         4'd4: e.data = a | b;
         4'd5: e.data = a ^ b;
         default: e.data = a;
      endcase
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] sel);
      req_a[i*DW +: DW]   = a;
      req_b[i*DW +: DW]   = b;
      req_sel[i*SW +: SW] = sel;
      req_valid[i]        = 1'b1;
   endtask

   task automatic new_op(input int i);
      logic [31:0] b;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 :
          ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      set_op(i, $urandom, b, 4'($urandom_range(0, 6)));
   endtask

   // One clock: sample handshakes at negedge, then update requesters after posedge.
   task automatic step(output logic [N-1:0] hs);
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (rand_rsp) rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
         if (hs[i]) begin
            if (auto_en[i] && $urandom_range(0, 99) < prob_pct) new_op(i);
            else req_valid[i] = 1'b0;
         end else if (auto_en[i] && !req_valid[i] && $urandom_range(0, 99) < prob_pct) begin
            new_op(i);
         end
      end
   endtask

   task automatic do_reset();
      logic [N-1:0] hs;
      auto_en   = '0;
      req_valid = '0;
      rst       = 1'b1;
      step(hs);
      step(hs);
      rst = 1'b0;
   endtask

   task automatic wait_done(input int max);
      logic [N-1:0] hs;
      int n = 0;
      while ((busy || req_valid != '0 || exp_q.size() != 0) && n < max) begin
         step(hs);
         n++;
      end
      chk("drain_within_bound", 64'(n < max), 64'd1);
   endtask

   task automatic monitor();
      exp_t         e;
      logic         prev_valid = 1'b0;
      logic [N-1:0] pend = '0;
      logic [N*DW-1:0] pa, pb;
      logic [N*SW-1:0] ps;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            exp_q.delete();
            mptr       = 0;
            prev_valid = 1'b0;
            pend       = '0;
            continue;
         end
         chk("busy", 64'(busy), 64'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            chk("ready_zero_while_busy", 64'(req_ready), 64'd0);
         end else begin
            int g = -1;
            logic [N-1:0] oh = '0;
            for (int k = 0; k < N; k++) begin
               int idx = (mptr + k) % N;
               if (g < 0 && req_valid[idx]) g = idx;
            end
            if (g >= 0) oh[g] = 1'b1;
            chk("grant", 64'(req_ready), 64'(oh));
         end
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
               e = exp_q[0];
               chk("rsp_id", 64'(rsp_id), 64'(e.id));
               chk("rsp_data", 64'(rsp_data), 64'(e.data));
               chk("rsp_carry", 64'(rsp_carry), 64'(e.carry));
               chk("rsp_dz", 64'(rsp_dz), 64'(e.dz));
               if (!prev_valid) chk("latency", 64'(cyc - e.cyc), 64'd2);
               if (rsp_ready) begin
                  void'(exp_q.pop_front());
                  mptr       = (e.id + 1) % N;
                  last_id    = int'(rsp_id);
                  last_data  = rsp_data;
                  last_carry = rsp_carry;
                  last_dz    = rsp_dz;
               end
            end
         end
         prev_valid = rsp_valid;
         if ((req_valid & req_ready) != '0 && exp_q.size() == 0) begin
            for (int i = 0; i < N; i++) begin
               if (req_valid[i] && req_ready[i]) begin
                  exp_q.push_back(ref_op(i, req_a[i*DW +: DW], req_b[i*DW +: DW],
                                         req_sel[i*SW +: SW], cyc));
                  grant_log.push_back(i);
                  grant_cyc.push_back(cyc);
               end
            end
         end
         for (int i = 0; i < N; i++) begin
            if (pend[i]) begin
               assert (req_valid[i] && req_a[i*DW +: DW] == pa[i*DW +: DW] &&
                       req_b[i*DW +: DW] == pb[i*DW +: DW] && req_sel[i*SW +: SW] == ps[i*SW +: SW])
                  else $error("requester %0d dropped or changed a pending request", i);
            end
         end
         pend = req_valid & ~req_ready;
         pa = req_a; pb = req_b; ps = req_sel;
      end
   endtask

   initial begin
      logic [N-1:0] hs;
      logic [31:0]  snap;
      int           n;
      rst = 1'b1; rsp_ready = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
      req_sel = '0; auto_en = '0; prob_pct = 0; rand_rsp = 1'b0;
      last_id = 0; last_data = '0; last_carry = 1'b0; last_dz = 1'b0;
      fork
         monitor();
      join_none

      // Reset state
      do_reset();
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_id", 64'(rsp_id), 64'd0);
      chk("rst_rsp_data", 64'(rsp_data), 64'd0);
      chk("rst_rsp_flags", 64'({rsp_carry, rsp_dz}), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_alu_ops", 64'({alu_a, alu_b} | 64'(alu_sel)), 64'd0);

      // Single request, same-cycle ready
      rsp_ready = 1'b1;
      set_op(0, 32'd5, 32'd7, 4'b0000);
      #1;
      chk("single_ready_same_cycle", 64'(req_ready), 64'b0001);
      wait_done(20);
      chk("single_data", 64'(last_data), 64'd12);
      chk("single_id", 64'(last_id), 64'd0);

      // All requesters continuously valid: strict rotation, one grant per 3 cycles
      do_reset();
      rsp_ready = 1'b1;
      grant_log.delete();
      grant_cyc.delete();
      prob_pct = 100;
      auto_en  = '1;
      for (int i = 0; i < N; i++) new_op(i);
      n = 0;
      while (grant_log.size() < 5 && n < 40) begin step(hs); n++; end
      auto_en = '0;
      chk("rotation_count", 64'(grant_log.size() >= 5), 64'd1);
      for (int k = 0; k < 5 && k < grant_log.size(); k++) begin
         chk("rotation_order", 64'(grant_log[k]), 64'(k % N));
         if (k > 0) chk("rotation_interval", 64'(grant_cyc[k] - grant_cyc[k-1]), 64'd3);
      end
      wait_done(60);

      // Back-pressure
      rsp_ready = 1'b0;
      set_op(2, 32'd1, 32'd2, 4'b0000);
      n = 0;
      while (!rsp_valid && n < 20) begin step(hs); n++; end
      chk("bp_rsp_appears", 64'(rsp_valid), 64'd1);
      set_op(0, 32'd3, 32'd4, 4'b0000);
      snap = rsp_data;
      for (int k = 0; k < 10; k++) begin
         step(hs);
         chk("bp_busy", 64'(busy), 64'd1);
         chk("bp_ready_zero", 64'(req_ready), 64'd0);
         chk("bp_rsp_held", 64'({rsp_valid, rsp_data}), 64'({1'b1, snap}));
      end
      rsp_ready = 1'b1;
      step(hs);
      step(hs);
      chk("bp_next_grant", 64'(hs), 64'b0001);
      wait_done(20);

      // Divide by zero, then ordinary divide
      set_op(2, 32'd100, 32'd0, 4'b0011);
      wait_done(20);
      chk("dz_id", 64'(last_id), 64'd2);
      chk("dz_result", 64'({last_dz, last_carry, last_data}), 64'({1'b1, 1'b0, 32'd0}));
      set_op(2, 32'd100, 32'd7, 4'b0011);
      wait_done(20);
      chk("div_result", 64'({last_dz, last_data}), 64'({1'b0, 32'd14}));

      // Carry out of an add
      set_op(1, 32'hFFFF_FFFF, 32'd1, 4'b0000);
      wait_done(20);
      chk("carry_result", 64'({last_carry, last_data}), 64'({1'b1, 32'd0}));

      // Reset during EXEC drops the operation and clears the pointer
      set_op(1, 32'd9, 32'd9, 4'b0000);
      hs = '0;
      n  = 0;
      while (!hs[1] && n < 20) begin step(hs); n++; end
      chk("mid_grant_seen", 64'(hs[1]), 64'd1);
      rst = 1'b1;
      set_op(3, 32'd30, 32'd3, 4'b0001);
      set_op(0, 32'd40, 32'd2, 4'b0010);
      step(hs);
      rst = 1'b0;
      chk("mid_rst_idle", 64'({busy, rsp_valid}), 64'd0);
      step(hs);
      chk("mid_rst_first_grant", 64'(hs), 64'b0001);
      wait_done(30);

      // Randomized traffic with random back-pressure
      prob_pct = 30;
      rand_rsp = 1'b1;
      auto_en  = '1;
      for (int k = 0; k < 1500; k++) step(hs);
      auto_en   = '0;
      rand_rsp  = 1'b0;
      rsp_ready = 1'b1;
      wait_done(100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
